noc_packet_ejector: RTL and testbench
=====================================

# noc_packet_ejector

- Sink at a mesh node's Local output port; the receiving end of the Req/Gnt/Full packet handshake that the per-node injectors drive.
- Accepts one 32-bit packet per handshake into a small FIFO and drains it at a programmable PE consumption rate.
- Checks each drained packet for correct destination and, optionally, per-source packet-ID sequence.
- Exposes delivered packets and saturating statistics counters to the traffic-generator top.

## Interface
- routerID, 6'b000_000, this node's position: [5:3] x, [2:0] y
- dataWidth, 32, packet width
- dim, 4, width of each x/y field: 1 direction bit + 3 position bits
- DEPTH, 4, FIFO entries (power of two, ≥2)
- DRAIN_PERIOD, 4, cycles between pops, ≥1
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low
- ReqUpStr  in  1  router requests delivery; held until Gnt seen
- PacketIn  in  dataWidth  packet, stable while ReqUpStr=1
- GntUpStr  out  1  one-cycle grant: packet captured
- UpStrFull  out  1  FIFO full, router must not request
- DeliverValid  out  1  one-cycle pulse per drained packet
- DeliverPacket  out  dataWidth  drained packet, valid with DeliverValid
- RxCount  out  16  packets drained, saturating
- MisrouteCount  out  16  drained packets with wrong destination, saturating
- SeqErrCount  out  16  sequence violations, saturating

## Operation
- Packet fields: [31:28] xDst, [27:24] yDst, [23:20] xSrc, [19:16] ySrc, [15:6] PacketID, [5:0] sender ModuleID.
- Reset (async, reset=0): state IDLE; FIFO empty; drain timer = DRAIN_PERIOD-1; GntUpStr, DeliverValid, DeliverPacket, all counters = 0; UpStrFull = 0; sequence table cleared.
- Receive FSM, 3 states:
  - IDLE: if ReqUpStr=1 and FIFO not full, then write PacketIn to FIFO, GntUpStr<=1, go to GRANT. If full, stay in IDLE and issue no grant.
  - GRANT: GntUpStr<=0, go to RELEASE.
  - RELEASE: wait until ReqUpStr=0, then go to IDLE. This blocks re-capture of a stale request.
- UpStrFull is combinational from the registered FIFO count: 1 iff count==DEPTH.
- Drain timer:
  - Increments each cycle, saturating at DRAIN_PERIOD-1.
  - Pop when timer==DRAIN_PERIOD-1 and count≠0. On a pop the timer is reset to 0.
- On pop:
  - DeliverValid<=1 and DeliverPacket<=head, both for one cycle.
  - RxCount increments.
  - MisrouteCount increments if xDst[2:0]≠routerID[5:3] or yDst[2:0]≠routerID[2:0]. Direction bits are ignored.
- Counters saturate at 16'hFFFF.
- Simultaneous push and pop in one cycle: count unchanged. A pop when empty cannot occur.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Capture at edge E (IDLE, Req=1, not full) → GntUpStr high during cycle E..E+1.
- Injector drops Req at E+1 → IDLE again by E+2. Handshake cost is 3 cycles per packet; max acceptance rate is one packet every 3 cycles.
- Pop is possible at edge E+1 at the earliest. DeliverValid is high during E+1..E+2 (latency 1 with DRAIN_PERIOD=1 or an idle saturated timer).
- Reset asserted mid-handshake: GntUpStr drops immediately. In-flight and FIFO contents are discarded; upstream must restart.

## Configuration
- EJECTOR_SEQ_CHECK_EN defined:
  - 64-entry table indexed by ModuleID, each entry {seen, lastID[9:0]}.
  - On pop with seen=0: store PacketID and set seen.
  - Otherwise, if PacketID≠lastID+1 (mod 1024), SeqErrCount increments. lastID is updated to the received PacketID in either case.
- Not defined: no table; SeqErrCount is constant 0.

## Structure
- Package ejector_pkg:
  - Field bit positions: X_DST_MSB … MODULE_ID_LSB.
  - State encodings: IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10.
  - COUNT_MAX=16'hFFFF.
- Sub-module ejector_fifo: DEPTH×dataWidth synchronous FIFO with push/pop/count/full/empty and async active-low reset. The FSM, drain timer, checks and counters stay in the top.

## Test plan
- Single packet 32'h2000_0041 to routerID 6'b010_000 (xDst=4'b0010), DRAIN_PERIOD=1 → GntUpStr pulses 1 cycle after Req; DeliverValid 1 cycle later with same data; RxCount=1, MisrouteCount=0.
- Five back-to-back requests, DRAIN_PERIOD=16, DEPTH=4 → UpStrFull=1 after 4th capture; 5th Req gets no grant until first pop; all five delivered in order.
- Packet with xDst=4'b1_011 at routerID 010_000 → MisrouteCount=1, RxCount=1, packet still delivered.
- With EJECTOR_SEQ_CHECK_EN, ModuleID 6'd5 IDs 1,2,4 → SeqErrCount=1. ID 1023 followed by 0 → no error. Without the macro, SeqErrCount stays 0.
- Reset asserted in GRANT with 2 packets queued → GntUpStr=0, UpStrFull=0, counters 0 immediately; no DeliverValid after release.
- Force RxCount to 16'hFFFE, deliver 3 packets → RxCount holds at 16'hFFFF.

Source files
------------

// File: rtl/ejector_pkg.sv
// rtl/ejector_pkg.sv - packet field positions, receive-FSM encodings and counter helpers for the ejector
package ejector_pkg;

    localparam int X_DST_MSB     = 31;
    localparam int X_DST_LSB     = 28;
    localparam int Y_DST_MSB     = 27;
    localparam int Y_DST_LSB     = 24;
    localparam int X_SRC_MSB     = 23;
    localparam int X_SRC_LSB     = 20;
    localparam int Y_SRC_MSB     = 19;
    localparam int Y_SRC_LSB     = 16;
    localparam int PACKET_ID_MSB = 15;
    localparam int PACKET_ID_LSB = 6;
    localparam int MODULE_ID_MSB = 5;
    localparam int MODULE_ID_LSB = 0;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_GRANT   = 2'b01;
    localparam logic [1:0] ST_RELEASE = 2'b10;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/noc_packet_ejector_if.sv
// rtl/noc_packet_ejector_if.sv - router Local-port Req/Gnt/Full packet handshake
interface noc_packet_ejector_if #(
    parameter int dataWidth = 32
) ();
    logic                 ReqUpStr;
    logic [dataWidth-1:0] PacketIn;
    logic                 GntUpStr;
    logic                 UpStrFull;

    modport master (output ReqUpStr, output PacketIn, input GntUpStr, input UpStrFull);
    modport slave  (input ReqUpStr, input PacketIn, output GntUpStr, output UpStrFull);
endinterface

// File: rtl/ejector_fifo.sv
// rtl/ejector_fifo.sv - DEPTH x WIDTH synchronous FIFO with registered occupancy count
module ejector_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/noc_packet_ejector.sv
// rtl/noc_packet_ejector.sv - Local-port packet sink with rate-limited drain and checks; EJECTOR_SEQ_CHECK_EN adds per-source ID sequence check
module noc_packet_ejector
    import ejector_pkg::*;
#(
    parameter logic [5:0] routerID     = 6'b000_000,
    parameter int         dataWidth    = 32,
    parameter int         dim          = 4,
    parameter int         DEPTH        = 4,
    parameter int         DRAIN_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    noc_packet_ejector_if.slave  up,
    output logic                 DeliverValid,
    output logic [dataWidth-1:0] DeliverPacket,
    output logic [15:0]          RxCount,
    output logic [15:0]          MisrouteCount,
    output logic [15:0]          SeqErrCount
);
    localparam int              CW        = $clog2(DEPTH) + 1;
    localparam int              TW        = $clog2(DRAIN_PERIOD + 1);
    localparam logic [TW-1:0]   TIMER_MAX = TW'(DRAIN_PERIOD - 1);

    logic [1:0]           state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 dv_q, dv_d;
    logic [dataWidth-1:0] dp_q, dp_d;
    logic [15:0]          rx_count_q, rx_count_d;
    logic [15:0]          mis_count_q, mis_count_d;

    logic                 push, pop, misroute;
    logic [dataWidth-1:0] head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full, fifo_empty;

    ejector_fifo #(.DEPTH(DEPTH), .WIDTH(dataWidth)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (up.PacketIn),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // RELEASE waits for Req to drop so a request still held from the last grant is not captured twice.
    always_comb begin
        state_d = state_q;
        gnt_d   = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (up.ReqUpStr && !fifo_full) begin
                    push    = 1'b1;
                    gnt_d   = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT:   state_d = ST_RELEASE;
            ST_RELEASE: if (!up.ReqUpStr) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop         = (timer_q == TIMER_MAX) && !fifo_empty;
        timer_d     = pop ? '0 : ((timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1));
        misroute    = (head[X_DST_LSB +: dim-1] != routerID[5:3]) ||
                      (head[Y_DST_LSB +: dim-1] != routerID[2:0]);
        dv_d        = pop;
        dp_d        = pop ? head : '0;
        rx_count_d  = pop ? sat_inc(rx_count_q) : rx_count_q;
        mis_count_d = (pop && misroute) ? sat_inc(mis_count_q) : mis_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            timer_q     <= TIMER_MAX;
            dv_q        <= 1'b0;
            dp_q        <= '0;
            rx_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            timer_q     <= timer_d;
            dv_q        <= dv_d;
            dp_q        <= dp_d;
            rx_count_q  <= rx_count_d;
            mis_count_q <= mis_count_d;
        end
    end

`ifdef EJECTOR_SEQ_CHECK_EN
    logic [63:0] seen_q, seen_d;
    logic [9:0]  last_q [64];
    logic [9:0]  last_d [64];
    logic [15:0] seq_count_q, seq_count_d;
    logic [5:0]  src_id;
    logic [9:0]  pkt_id;
    logic        seq_err;

    // The first packet from a source only primes its entry; later ones must follow lastID+1 mod 1024.
    always_comb begin
        src_id  = head[MODULE_ID_MSB:MODULE_ID_LSB];
        pkt_id  = head[PACKET_ID_MSB:PACKET_ID_LSB];
        seen_d  = seen_q;
        last_d  = last_q;
        seq_err = pop && seen_q[src_id] && (pkt_id != last_q[src_id] + 10'd1);
        if (pop) begin
            seen_d[src_id] = 1'b1;
            last_d[src_id] = pkt_id;
        end
        seq_count_d = seq_err ? sat_inc(seq_count_q) : seq_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen_q      <= '0;
            seq_count_q <= '0;
            for (int i = 0; i < 64; i++) begin
                last_q[i] <= '0;
            end
        end else begin
            seen_q      <= seen_d;
            last_q      <= last_d;
            seq_count_q <= seq_count_d;
        end
    end

    assign SeqErrCount = seq_count_q;
`else
    assign SeqErrCount = '0;
`endif

    assign up.GntUpStr   = gnt_q;
    assign up.UpStrFull  = (fifo_count == CW'(DEPTH));
    assign DeliverValid  = dv_q;
    assign DeliverPacket = dp_q;
    assign RxCount       = rx_count_q;
    assign MisrouteCount = mis_count_q;
endmodule

// File: tb/tb_noc_packet_ejector.sv
// tb/tb_noc_packet_ejector.sv - scoreboard bench for noc_packet_ejector (routerID 010_000, DEPTH 4, DRAIN_PERIOD 16)
module tb_noc_packet_ejector;

    typedef struct {
        logic [31:0] pkt;
        int          rx;
        int          mis;
        int          seq;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        DeliverValid;
    logic [31:0] DeliverPacket;
    logic [15:0] RxCount, MisrouteCount, SeqErrCount;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   req_cyc, gnt_cyc, g4;
    int   n_before;
    bit   mon_en  = 1'b0;
    exp_t exp_q[$];
    int   del_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    noc_packet_ejector_if #(.dataWidth(32)) up_if ();

    noc_packet_ejector #(
        .routerID     (6'b010_000),
        .dataWidth    (32),
        .dim          (4),
        .DEPTH        (4),
        .DRAIN_PERIOD (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .up            (up_if),
        .DeliverValid  (DeliverValid),
        .DeliverPacket (DeliverPacket),
        .RxCount       (RxCount),
        .MisrouteCount (MisrouteCount),
        .SeqErrCount   (SeqErrCount)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] x, input logic [3:0] y,
                                       input logic [9:0] pid, input logic [5:0] mid);
        return {x, y, 4'h0, 4'h0, pid, mid};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && DeliverValid === 1'b1) begin
            del_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_deliver", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("deliver_pkt", DeliverPacket, e.pkt);
                check("rx_count", {16'h0, RxCount}, e.rx);
                check("misroute_count", {16'h0, MisrouteCount}, e.mis);
                check("seq_err_count", {16'h0, SeqErrCount}, e.seq);
            end
        end
    end

    task automatic send(input logic [31:0] pkt, input int rx, input int mis, input int seq);
        int   n;
        int   s;
        exp_t e;
`ifdef EJECTOR_SEQ_CHECK_EN
        s = seq;
`else
        s = 0;
`endif
        @(negedge clk);
        up_if.ReqUpStr = 1'b1;
        up_if.PacketIn = pkt;
        req_cyc = cyc;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (up_if.GntUpStr !== 1'b1 && n < 200);
        if (up_if.GntUpStr !== 1'b1) begin
            check("grant_timeout", 32'd0, 32'd1);
            up_if.ReqUpStr = 1'b0;
            return;
        end
        gnt_cyc = cyc;
        e.pkt = pkt; e.rx = rx; e.mis = mis; e.seq = s;
        exp_q.push_back(e);
        up_if.ReqUpStr = 1'b0;
        @(posedge clk);
        #1;
        check("gnt_one_cycle", {31'h0, up_if.GntUpStr}, 32'd0);
        @(posedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        up_if.ReqUpStr = 1'b0;
        up_if.PacketIn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {31'h0, up_if.GntUpStr}, 32'd0);
        check("rst_full", {31'h0, up_if.UpStrFull}, 32'd0);
        check("rst_dv", {31'h0, DeliverValid}, 32'd0);
        check("rst_dp", DeliverPacket, 32'd0);
        check("rst_rx", {16'h0, RxCount}, 32'd0);
        check("rst_mis", {16'h0, MisrouteCount}, 32'd0);
        check("rst_seq", {16'h0, SeqErrCount}, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);

        // single packet to this node: grant one cycle after Req, delivery one cycle after grant
        send(32'h2000_0041, 1, 0, 0);
        check("gnt_latency", gnt_cyc, req_cyc + 1);
        wait_drain();
        check("deliver_latency", del_cyc[del_cyc.size()-1], gnt_cyc + 1);
        repeat (20) @(negedge clk);

        send(mk(4'b1011, 4'b0000, 10'd1, 6'd2), 2, 1, 0);
        wait_drain();
        repeat (20) @(negedge clk);

        // direction bits set but position matches; its immediate pop resets the drain timer
        send(mk(4'b1010, 4'b1000, 10'd2, 6'd3), 3, 1, 0);

        send(mk(4'b0010, 4'b0000, 10'd1, 6'd5), 4, 1, 0);
        send(mk(4'b0010, 4'b0000, 10'd2, 6'd5), 5, 1, 0);
        send(mk(4'b0010, 4'b0000, 10'd4, 6'd5), 6, 1, 1);
        send(mk(4'b0010, 4'b0000, 10'd1023, 6'd6), 7, 1, 1);
        g4 = gnt_cyc;
        #1;
        check("full_after_4th", {31'h0, up_if.UpStrFull}, 32'd1);
        send(mk(4'b0010, 4'b0000, 10'd0, 6'd6), 8, 1, 1);
        check("gnt5_waits_for_pop", gnt_cyc - g4, 32'd6);
        wait_drain();
        n = del_cyc.size();
        for (int i = n - 6; i < n - 1; i++) begin
            check("drain_spacing", del_cyc[i+1] - del_cyc[i], 32'd16);
        end

        // reset while in GRANT with two packets queued
        send(mk(4'b0010, 4'b0000, 10'd0, 6'd7), 9, 1, 1);
        @(negedge clk);
        up_if.ReqUpStr = 1'b1;
        up_if.PacketIn = mk(4'b0010, 4'b0000, 10'd1, 6'd7);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (up_if.GntUpStr !== 1'b1 && n < 200);
        check("grant_before_reset", {31'h0, up_if.GntUpStr}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_gnt", {31'h0, up_if.GntUpStr}, 32'd0);
        check("rst_mid_full", {31'h0, up_if.UpStrFull}, 32'd0);
        check("rst_mid_rx", {16'h0, RxCount}, 32'd0);
        check("rst_mid_mis", {16'h0, MisrouteCount}, 32'd0);
        check("rst_mid_seq", {16'h0, SeqErrCount}, 32'd0);
        exp_q.delete();
        up_if.ReqUpStr = 1'b0;
        n_before = del_cyc.size();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("no_deliver_after_reset", del_cyc.size(), n_before);

        // saturation of RxCount
        force dut.rx_count_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.rx_count_q;
        send(mk(4'b0010, 4'b0000, 10'd0, 6'd8), 32'hFFFF, 0, 0);
        send(mk(4'b0010, 4'b0000, 10'd1, 6'd8), 32'hFFFF, 0, 0);
        send(mk(4'b0010, 4'b0000, 10'd2, 6'd8), 32'hFFFF, 0, 0);
        wait_drain();
        check("rx_saturated", {16'h0, RxCount}, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
